// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Host writes land in a shadow bank; a commit copies it to the displayed bank at a frame boundary.
`timescale 1ns/1ps
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 4000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  commit,
    input  logic                  lz_blank,
    output logic [3:0]            bcd_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    // With no blank phase every slot opens directly in SHOW.
    localparam state_t SLOT_ST = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0] shadow_q;
    logic [NUM_DIGITS-1:0][3:0] active_q;
    logic                       pend_q;
    logic [NUM_DIGITS-1:0]      sel_q, sel_d;
    logic [3:0]                 bcd_q, bcd_d;
    logic                       frame_q, frame_d;
    logic                       slot_start;
    logic                       copy_en;
    logic                       wr_fire;

    function automatic logic [3:0] digit_value(
        input logic [NUM_DIGITS-1:0][3:0] bank,
        input logic [IDX_W-1:0]           i,
        input logic                       lz
    );
        logic [3:0] v;
        logic       upper_zero;
        v          = 4'h0;
        upper_zero = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            if (j >= int'(i) && bank[j] != 4'h0) upper_zero = 1'b0;
            if (j == int'(i)) v = bank[j];
        end
        if (lz && i != '0 && upper_zero) v = 4'hF;
        return v;
    endfunction

    // The copy cycle steals the write port so shadow is stable while it is copied.
    assign copy_en  = pend_q && (frame_q || state_q == IDLE);
    assign wr_ready = !copy_en;
    assign wr_fire  = wr_valid && wr_ready && ({1'b0, wr_addr} < 4'(NUM_DIGITS));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        slot_start = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d    = SLOT_ST;
                    slot_start = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d    = SLOT_ST;
                    cnt_d      = '0;
                    idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    slot_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        sel_d   = (state_d == SHOW) ? (ONE_HOT << idx_d) : '0;
        frame_d = slot_start && (idx_d == '0);
        if (state_d == IDLE)  bcd_d = 4'hF;
        else if (slot_start)  bcd_d = digit_value(active_q, idx_d, lz_blank);
        else                  bcd_d = bcd_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
            sel_q    <= '0;
            bcd_q    <= 4'hF;
            frame_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            bcd_q   <= bcd_d;
            frame_q <= frame_d;
            // A commit arriving in the copy cycle re-arms for the next boundary.
            pend_q  <= copy_en ? commit : (pend_q | commit);
            if (copy_en) active_q <= shadow_q;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_fire && wr_addr == 3'(i)) shadow_q[i] <= wr_data;
            end
        end
    end

    assign digit_sel   = sel_q;
    assign bcd_out     = bcd_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 8-cycle slots with a 2-cycle blank, 32-cycle frames.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic       lz_blank;
    logic [3:0] bcd_out;
    logic [3:0] digit_sel;
    logic       frame_start;

    int    n_chk = 0;
    int    n_err = 0;
    string phase = "init";

    seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .lz_blank   (lz_blank),
        .bcd_out    (bcd_out),
        .digit_sel  (digit_sel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Walk one full frame from its first cycle; returns at the first cycle of the next frame.
    task automatic check_frame(input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] dv [4];
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        for (int c = 0; c < 32; c++) begin
            int slot;
            int pos;
            slot = c / 8;
            pos  = c % 8;
            check("frame_start", frame_start, (c == 0) ? 1 : 0);
            check("digit_sel", digit_sel, (pos < 2) ? 0 : (1 << slot));
            check("bcd_out", bcd_out, dv[slot]);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; enable = 1'b0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; commit = 1'b0; lz_blank = 1'b0;

        phase = "reset";
        ticks(2);
        check("digit_sel", digit_sel, 0);
        check("bcd_out", bcd_out, 4'hF);
        check("frame_start", frame_start, 0);
        check("wr_ready", wr_ready, 1);
        reset = 1'b1;
        tick();
        check("idle_sel", digit_sel, 0);
        check("idle_bcd", bcd_out, 4'hF);

        phase = "scan_zero";
        enable = 1'b1;
        tick();
        check_frame(4'h0, 4'h0, 4'h0, 4'h0);

        phase = "commit_midframe";
        check("frame_again", frame_start, 1);
        check("ready_c0", wr_ready, 1);
        for (int a = 0; a < 4; a++) begin
            wr_valid = 1'b1; wr_addr = 3'(a); wr_data = 4'(a + 1);
            check("ready_wr", wr_ready, 1);
            tick();
        end
        wr_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int c = 5; c < 32; c++) begin
            check("hold_bcd", bcd_out, 0);
            check("hold_ready", wr_ready, 1);
            tick();
        end
        check("copy_frame", frame_start, 1);
        check("copy_ready", wr_ready, 0);
        check("copy_bcd0", bcd_out, 0);
        tick();
        check("after_copy_ready", wr_ready, 1);
        ticks(31);
        check_frame(4'h1, 4'h2, 4'h3, 4'h4);

        phase = "lz_blank";
        wr_valid = 1'b1;
        wr_addr = 3'd0; wr_data = 4'd0; tick();
        wr_addr = 3'd1; wr_data = 4'd5; tick();
        wr_addr = 3'd2; wr_data = 4'd0; tick();
        wr_addr = 3'd3; wr_data = 4'd0; commit = 1'b1; tick();
        commit = 1'b0;
        wr_addr = 3'd4; wr_data = 4'd9;
        check("ready_oob", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        lz_blank = 1'b1;
        ticks(27);
        check("lz_copy_ready", wr_ready, 0);
        ticks(32);
        check_frame(4'h0, 4'h5, 4'hF, 4'hF);
        lz_blank = 1'b0;
        check_frame(4'h0, 4'h5, 4'h0, 4'h0);

        phase = "commit_in_copy";
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        ticks(30);
        check("cc_frame", frame_start, 1);
        check("cc_ready", wr_ready, 0);
        commit = 1'b1; wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'd9;
        tick();
        commit = 1'b0;
        check("cc_ready_next", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        ticks(30);
        check("cc_pend_kept", wr_ready, 0);
        ticks(32);
        check_frame(4'h0, 4'h5, 4'h9, 4'h0);

        phase = "enable_drop";
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 4'd7;
        check("ed_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        ticks(18);
        check("ed_show2", digit_sel, 4'b0100);
        enable = 1'b0;
        tick();
        check("ed_sel", digit_sel, 0);
        check("ed_bcd", bcd_out, 4'hF);
        check("ed_frame", frame_start, 0);
        check("ed_idle_copy", wr_ready, 0);
        tick();
        check("ed_ready_back", wr_ready, 1);
        check("ed_sel_idle", digit_sel, 0);
        enable = 1'b1;
        tick();
        check_frame(4'h0, 4'h5, 4'h9, 4'h7);

        phase = "reset_midshow";
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'd8;
        tick();
        wr_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        ticks(10);
        check("rs_show1", digit_sel, 4'b0010);
        reset = 1'b0;
        tick();
        check("rs_sel", digit_sel, 0);
        check("rs_bcd", bcd_out, 4'hF);
        check("rs_frame", frame_start, 0);
        check("rs_ready", wr_ready, 1);
        reset = 1'b1;
        tick();
        check_frame(4'h0, 4'h0, 4'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
